// File: rtl/alu.sv
// 64-bit LEGv8 integer ALU with an NZCV condition-flag register.
// Latency: result and live flags are combinational; registered flags follow one clk edge after SetFlags.
// Backpressure: none, because every cycle accepts new operands and the flag register only holds between updates.
module alu #(
    parameter int WORD = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    input  logic [3:0]      ALUCtl,
    input  logic            SetFlags,
    output logic [WORD-1:0] ALUOut,
    output logic            Zero,
    output logic            Negative,
    output logic            Co,
    output logic            Overflow,
    output logic            FlagN,
    output logic            FlagZ,
    output logic            FlagC,
    output logic            FlagV
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_EOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_LSL  = 4'b1000;
    localparam logic [3:0] ALU_LSR  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    logic [WORD:0] add_ext;
    logic [WORD:0] sub_ext;
    logic [5:0]    shamt;

    // Extra top bit of each sum is the unsigned carry; for SUB it reads as "no borrow".
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WORD{1'b0}}, 1'b1};
    assign shamt   = b[5:0];

    always_comb begin
        ALUOut   = '0;
        Co       = 1'b0;
        Overflow = 1'b0;
        case (ALUCtl)
            ALU_AND:  ALUOut = a & b;
            ALU_OR:   ALUOut = a | b;
            ALU_ADD: begin
                ALUOut   = add_ext[WORD-1:0];
                Co       = add_ext[WORD];
                Overflow = (a[WORD-1] == b[WORD-1]) && (add_ext[WORD-1] != a[WORD-1]);
            end
            ALU_EOR:  ALUOut = a ^ b;
            ALU_SUB: begin
                ALUOut   = sub_ext[WORD-1:0];
                Co       = sub_ext[WORD];
                Overflow = (a[WORD-1] != b[WORD-1]) && (sub_ext[WORD-1] != a[WORD-1]);
            end
            ALU_PASS: ALUOut = b;
            ALU_LSL:  ALUOut = a << shamt;
            ALU_LSR:  ALUOut = a >> shamt;
            ALU_NOR:  ALUOut = ~(a | b);
            default:  ALUOut = '0;
        endcase
    end

    assign Zero     = (ALUOut == '0);
    assign Negative = ALUOut[WORD-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            FlagN <= 1'b0;
            FlagZ <= 1'b0;
            FlagC <= 1'b0;
            FlagV <= 1'b0;
        end else if (SetFlags) begin
            FlagN <= Negative;
            FlagZ <= Zero;
            FlagC <= Co;
            FlagV <= Overflow;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: combinational result/NZCV checks and flag register update/hold/reset.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ALUCtl;
    logic        SetFlags;
    logic [63:0] ALUOut;
    logic        Zero;
    logic        Negative;
    logic        Co;
    logic        Overflow;
    logic        FlagN;
    logic        FlagZ;
    logic        FlagC;
    logic        FlagV;

    int checks = 0;
    int passes = 0;

    alu #(.WORD(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .ALUCtl   (ALUCtl),
        .SetFlags (SetFlags),
        .ALUOut   (ALUOut),
        .Zero     (Zero),
        .Negative (Negative),
        .Co       (Co),
        .Overflow (Overflow),
        .FlagN    (FlagN),
        .FlagZ    (FlagZ),
        .FlagC    (FlagC),
        .FlagV    (FlagV)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Apply operands, let combinational logic settle, then check result and live NZCV.
    task automatic op(input string tag, input logic [3:0] ctl, input logic [63:0] va,
                      input logic [63:0] vb, input logic [63:0] exp_out, input logic [3:0] exp_nzcv);
        ALUCtl = ctl;
        a      = va;
        b      = vb;
        #1;
        check({tag, "_out"}, ALUOut, exp_out);
        check({tag, "_nzcv"}, {60'd0, Negative, Zero, Co, Overflow}, {60'd0, exp_nzcv});
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp_nzcv);
        check(tag, {60'd0, FlagN, FlagZ, FlagC, FlagV}, {60'd0, exp_nzcv});
    endtask

    initial begin
        rst      = 1'b1;
        SetFlags = 1'b0;
        ALUCtl   = 4'b0000;
        a        = '0;
        b        = '0;
        @(posedge clk); #1;
        check_flags("reset_flags", 4'b0000);
        rst = 1'b0;

        // Arithmetic
        op("add_max_pos",  4'b0010, 64'h7FFF_FFFF_FFFF_FFFE, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0000);
        op("add_wrap_zero",4'b0010, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3, 64'h0, 4'b0110);
        op("add_sovf",     4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b1001);
        op("sub_neg_minus1",4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 4'b1000);
        op("sub_sovf",     4'b0110, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
        op("sub_equal",    4'b0110, 64'h1234, 64'h1234, 64'h0, 4'b0110);

        // Logic and pass
        op("and",  4'b0000, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3, 64'h1, 4'b0000);
        op("or",   4'b0001, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
        op("pass", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3, 64'h3, 4'b0000);
        op("nor",  4'b1100, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3, 64'h0, 4'b0100);
        op("eor",  4'b0011, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);

        // Shifts: only b[5:0] counts
        op("lsl63",     4'b1000, 64'h1, 64'd63, 64'h8000_0000_0000_0000, 4'b1000);
        op("lsr63",     4'b1001, 64'h8000_0000_0000_0000, 64'd63, 64'h1, 4'b0000);
        op("lsl_hib",   4'b1000, 64'h1, 64'hFFFF_FFFF_FFFF_FFC4, 64'h10, 4'b0000);
        op("lsr_zero",  4'b1001, 64'h1234, 64'h40, 64'h1234, 4'b0000);

        // Undefined codes
        op("undef_0101", 4'b0101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b0100);
        op("undef_1111", 4'b1111, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'b0100);

        // Flag register: capture, hold, recapture, reset priority
        op("fr_add_zero", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3, 64'h0, 4'b0110);
        SetFlags = 1'b1;
        #1;
        check_flags("fr_before_edge", 4'b0000);
        @(posedge clk); #1;
        check_flags("fr_capture", 4'b0110);
        SetFlags = 1'b0;
        op("fr_live_sub", 4'b0110, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
        @(posedge clk); #1;
        check_flags("fr_hold", 4'b0110);
        @(posedge clk); #1;
        check_flags("fr_hold2", 4'b0110);
        SetFlags = 1'b1;
        @(posedge clk); #1;
        check_flags("fr_recapture", 4'b0011);
        rst = 1'b1;
        #1;
        check("rst_comb_out", ALUOut, 64'h7FFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        check_flags("fr_rst_prio", 4'b0000);
        rst      = 1'b0;
        SetFlags = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
